// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard unit for a 5-stage RISC-V pipeline.
//   - Computes the EX operand forward selects in ID and registers them when
//     the ID instruction moves into EX.
//   - Detects load-use hazards against the instruction currently in EX.
//   - Keeps a per-register countdown scoreboard for multicycle writebacks.
//
// Ports
//   clk, rst        pipeline clock, asynchronous active-low reset
//   id_rs1/2        ID source registers; id_use_rs1/2 mark real reads
//   ex_valid/rd/rw  EX instruction and its destination
//   ex_is_load      EX instruction is a load
//   ex_lat          extra writeback latency of EX instruction (0 = single cycle)
//   mem_rd/rw       MEM destination (mem_rw held low for multicycle ops)
//   ext_stall       external freeze of all pipeline registers
//   flush           kill the ID instruction
//   rs1_sel/rs2_sel registered EX forward select: 00 regfile, 10 MEM, 01 WB
//   stall           combinational: hold IF/ID, inject bubble into EX
//   sb_busy         bit r set while scoreboard counter r is nonzero
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_ADDR_W-1:0]        id_rs1,
  input  logic [REG_ADDR_W-1:0]        id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic                         ex_valid,
  input  logic [REG_ADDR_W-1:0]        ex_rd,
  input  logic                         ex_rw,
  input  logic                         ex_is_load,
  input  logic [LAT_W-1:0]             ex_lat,
  input  logic [REG_ADDR_W-1:0]        mem_rd,
  input  logic                         mem_rw,
  input  logic                         ext_stall,
  input  logic                         flush,
  output logic [1:0]                   rs1_sel,
  output logic [1:0]                   rs2_sel,
  output logic                         stall,
  output logic [(2**REG_ADDR_W)-1:0]   sb_busy
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [LAT_W-1:0] cnt [NUM_REGS];

  logic hit1, hit2;
  logic ex_fwd_ok, mem_fwd_ok, ex_load_ok;
  logic load_use, sb_hazard;
  logic advance;
  logic ex_issue;
  logic [1:0] sel1_nxt, sel2_nxt;

  // x0 is excluded here, so it can never stall or be forwarded.
  assign hit1 = id_use_rs1 & (id_rs1 != '0);
  assign hit2 = id_use_rs2 & (id_rs2 != '0);

  // Only single-cycle producers forward; multicycle results reach the
  // regfile before the scoreboard releases the consumer.
  assign ex_fwd_ok  = ex_valid & ex_rw & (ex_lat == '0) & (ex_rd != '0);
  assign mem_fwd_ok = mem_rw & (mem_rd != '0);
  assign ex_load_ok = ex_valid & ex_is_load & ex_rw & (ex_rd != '0);

  assign load_use  = (ex_load_ok & hit1 & (ex_rd == id_rs1)) |
                     (ex_load_ok & hit2 & (ex_rd == id_rs2));
  assign sb_hazard = (hit1 & (cnt[id_rs1] != '0)) |
                     (hit2 & (cnt[id_rs2] != '0));

  assign stall   = (load_use | sb_hazard) & ~flush;
  assign advance = ~stall & ~ext_stall;

  assign ex_issue = ex_valid & ex_rw & (ex_rd != '0) & (ex_lat != '0) & ~ext_stall;

  // The EX producer will sit in MEM when the consumer reaches EX, so it
  // takes priority over the older MEM producer (which will be in WB).
  always_comb begin
    sel1_nxt = 2'b00;
    sel2_nxt = 2'b00;
    if (hit1 && ex_fwd_ok && (ex_rd == id_rs1))
      sel1_nxt = 2'b10;
    else if (hit1 && mem_fwd_ok && (mem_rd == id_rs1))
      sel1_nxt = 2'b01;
    if (hit2 && ex_fwd_ok && (ex_rd == id_rs2))
      sel2_nxt = 2'b10;
    else if (hit2 && mem_fwd_ok && (mem_rd == id_rs2))
      sel2_nxt = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_sel <= 2'b00;
      rs2_sel <= 2'b00;
    end else if (ext_stall) begin
      rs1_sel <= rs1_sel;
      rs2_sel <= rs2_sel;
    end else if (flush || stall) begin
      rs1_sel <= 2'b00;
      rs2_sel <= 2'b00;
    end else if (advance) begin
      rs1_sel <= sel1_nxt;
      rs2_sel <= sel2_nxt;
    end
  end

  // Counters run free through ext_stall and flush: the multicycle unit is
  // not frozen with the pipeline. A new issue reloads the counter, so the
  // most recent writer to a register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ex_issue && (ex_rd == REG_ADDR_W'(i)))
          cnt[i] <= ex_lat;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    sb_busy = '0;
    for (int i = 0; i < NUM_REGS; i++)
      sb_busy[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Stimulus runs one cycle at a time
// (inputs driven 1 time unit after the rising edge) and queues the
// expected outputs; a monitor samples on the falling edge and compares.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_valid, ex_rw, ex_is_load, mem_rw;
  logic [3:0]  ex_lat;
  logic        ext_stall, flush;
  logic [1:0]  rs1_sel, rs2_sel;
  logic        stall;
  logic [31:0] sb_busy;

  fwd_hazard_unit #(.REG_ADDR_W(5), .LAT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_rw(ex_rw),
    .ex_is_load(ex_is_load), .ex_lat(ex_lat),
    .mem_rd(mem_rd), .mem_rw(mem_rw),
    .ext_stall(ext_stall), .flush(flush),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .stall(stall), .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s.%s actual=%h expected=%h", name, field, act, want);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "stall",   {31'd0, stall},   {31'd0, e.st});
      cmp(e.name, "rs1_sel", {30'd0, rs1_sel}, {30'd0, e.s1});
      cmp(e.name, "rs2_sel", {30'd0, rs2_sel}, {30'd0, e.s2});
      cmp(e.name, "sb_busy", sb_busy,          e.busy);
    end
  end

  task automatic chk(input string n, input logic st, input logic [1:0] s1,
                     input logic [1:0] s2, input logic [31:0] busy);
    exp_t e;
    e.name = n; e.st = st; e.s1 = s1; e.s2 = s2; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_rw = 0; ex_is_load = 0; ex_lat = 0;
    mem_rd = 0; mem_rw = 0; ext_stall = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic id(input logic [4:0] r1, input logic u1,
                    input logic [4:0] r2, input logic u2);
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
  endtask

  task automatic ex(input logic v, input logic [4:0] rd, input logic rw,
                    input logic ld, input logic [3:0] lat);
    ex_valid = v; ex_rd = rd; ex_rw = rw; ex_is_load = ld; ex_lat = lat;
  endtask

  task automatic mem(input logic [4:0] rd, input logic rw);
    mem_rd = rd; mem_rw = rw;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] B4  = 32'h1 << 4;
  localparam logic [31:0] B9  = 32'h1 << 9;
  localparam logic [31:0] B10 = 32'h1 << 10;
  localparam logic [31:0] B11 = 32'h1 << 11;

  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    chk("reset", 0, 2'b00, 2'b00, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU chain: EX forward, then MEM->WB forward, then MEM priority
    step(); ex(1, 5, 1, 0, 0); id(5, 1, 0, 0);           chk("alu_a", 0, 2'b00, 2'b00, 0);
    step(); mem(5, 1); id(0, 0, 5, 1);                    chk("alu_ex_fwd", 0, 2'b10, 2'b00, 0);
    step(); mem(5, 1); ex(1, 5, 1, 0, 0); id(5, 1, 0, 0); chk("alu_wb_fwd", 0, 2'b00, 2'b01, 0);
    step();                                               chk("alu_mem_prio", 0, 2'b10, 2'b00, 0);

    // Load-use: one bubble, then forward from WB
    step(); ex(1, 7, 1, 1, 0); id(0, 0, 7, 1);            chk("lu_stall", 1, 2'b00, 2'b00, 0);
    step(); mem(7, 1); id(0, 0, 7, 1);                    chk("lu_bubble", 0, 2'b00, 2'b00, 0);
    step();                                               chk("lu_wb_fwd", 0, 2'b00, 2'b01, 0);

    // Multicycle x9, latency 3: stall exactly three cycles
    step(); ex(1, 9, 1, 0, 3);                            chk("mc_issue", 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      step(); id(9, 1, 0, 0);                             chk("mc_wait", 1, 2'b00, 2'b00, B9);
    end
    step(); id(9, 1, 0, 0);                               chk("mc_release", 0, 2'b00, 2'b00, 0);

    // x0 writes never stall, forward or mark busy
    step(); ex(1, 0, 1, 0, 5); mem(0, 1); id(0, 1, 0, 1); chk("x0_mc", 0, 2'b00, 2'b00, 0);
    step(); ex(1, 0, 1, 1, 0); mem(0, 1); id(0, 1, 0, 1); chk("x0_load", 0, 2'b00, 2'b00, 0);
    step();                                               chk("x0_after", 0, 2'b00, 2'b00, 0);

    // WAW: x4 lat 5, reissued lat 2 two cycles later
    step(); ex(1, 4, 1, 0, 5);                            chk("waw_i1", 0, 2'b00, 2'b00, 0);
    step();                                               chk("waw_busy", 0, 2'b00, 2'b00, B4);
    step(); ex(1, 4, 1, 0, 2);                            chk("waw_i2", 0, 2'b00, 2'b00, B4);
    step(); id(0, 0, 4, 1);                               chk("waw_c2", 1, 2'b00, 2'b00, B4);
    step(); id(0, 0, 4, 1);                               chk("waw_c1", 1, 2'b00, 2'b00, B4);
    step(); id(0, 0, 4, 1);                               chk("waw_clear", 0, 2'b00, 2'b00, 0);

    // ext_stall holds selects while counters keep running
    step(); ex(1, 10, 1, 0, 2);                           chk("es_issue", 0, 2'b00, 2'b00, 0);
    step(); ex(1, 6, 1, 0, 0); id(6, 1, 0, 0);            chk("es_pre", 0, 2'b00, 2'b00, B10);
    step(); ext_stall = 1; mem(6, 1); id(0, 0, 6, 1);     chk("es_frozen", 0, 2'b10, 2'b00, B10);
    step(); mem(6, 1); id(0, 0, 6, 1);                    chk("es_held", 0, 2'b10, 2'b00, 0);
    step(); ex(1, 2, 1, 0, 0); id(2, 1, 2, 1);            chk("es_resume", 0, 2'b00, 2'b01, 0);

    // flush with a load-use condition present
    step(); flush = 1; ex(1, 8, 1, 1, 0); id(8, 1, 8, 1); chk("fl_nostall", 0, 2'b10, 2'b10, 0);
    step();                                               chk("fl_cleared", 0, 2'b00, 2'b00, 0);

    // Async reset with counters busy and a select loaded
    step(); ex(1, 11, 1, 0, 7);                           chk("ar_issue", 0, 2'b00, 2'b00, 0);
    step(); ex(1, 12, 1, 0, 0); id(12, 1, 0, 0);          chk("ar_busy", 0, 2'b00, 2'b00, B11);
    step(); ex(1, 12, 1, 0, 0); id(12, 1, 0, 0);          chk("ar_loaded", 0, 2'b10, 2'b00, B11);
    step(); rst = 1'b0;                                   chk("ar_async", 0, 2'b00, 2'b00, 0);
    step(); rst = 1'b1;                                   chk("ar_release", 0, 2'b00, 2'b00, 0);
    step(); id(11, 1, 0, 0);                              chk("ar_untracked", 0, 2'b00, 2'b00, 0);

    step();
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
